// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared constants, buffer-entry type and clog2 helper for stream_mux_nbit
package stream_mux_pkg;
  localparam int DEPTH = 2;
  localparam int N_MAX = 64;
  localparam int SW_MAX = 4;
  typedef struct packed {
    logic [N_MAX-1:0]  data;
    logic [SW_MAX-1:0] src;
  } entry_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/stream_mux_nbit_rr_arbiter.sv
// rr_arbiter: picks one requester, round-robin from last+1 when STREAM_MUX_RR_EN is defined, else lowest index
module rr_arbiter #(
  parameter int M  = 8,
  parameter int SW = 3
) (
  input  logic [M-1:0]  req,
  input  logic [SW-1:0] last,
  output logic [SW-1:0] grant,
  output logic          any
);
  assign any = |req;
`ifdef STREAM_MUX_RR_EN
  always_comb begin
    grant = '0;
    for (int i = M; i >= 1; i--) if (req[last + SW'(i)]) grant = last + SW'(i);
  end
`else
  logic unused_last;
  assign unused_last = ^last;
  always_comb begin
    grant = '0;
    for (int i = M - 1; i >= 0; i--) if (req[i]) grant = SW'(i);
  end
`endif
endmodule

// File: rtl/stream_mux_nbit.sv
// stream_mux_nbit: merges M valid/ready channels into a 2-entry source-tagged output buffer; STREAM_MUX_RR_EN selects round-robin over fixed priority
module stream_mux_nbit
  import stream_mux_pkg::*;
#(
  parameter int N = 64,
  parameter int M = 8,
  localparam int SW = clog2(M)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [M*N-1:0] i_data,
  input  logic [M-1:0]   i_valid,
  output logic [M-1:0]   i_ready,
  output logic [N-1:0]   F,
  output logic [SW-1:0]  F_src,
  output logic           F_valid,
  input  logic           F_ready
);
  logic [1:0]    count_q, count_d;
  logic          wr_q, wr_d, rd_q, rd_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [SW-1:0] g, rr_last;
  logic          any, push, pop, unused_bits;
  rr_arbiter #(.M(M), .SW(SW)) u_arb (
    .req  (i_valid),
    .last (rr_last),
    .grant(g),
    .any  (any)
  );
`ifdef STREAM_MUX_RR_EN
  logic [SW-1:0] rr_last_q, rr_last_d;
  assign rr_last = rr_last_q;
  assign rr_last_d = push ? g : rr_last_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rr_last_q <= SW'(M - 1);
    else rr_last_q <= rr_last_d;
  end
`else
  assign rr_last = SW'(M - 1);
`endif
  assign push = any && (count_q != 2'(DEPTH));
  assign pop = F_valid && F_ready;
  assign i_ready = push ? (M'(1) << g) : '0;
  assign F_valid = count_q != '0;
  assign F = mem_q[rd_q].data[N-1:0];
  assign F_src = mem_q[rd_q].src[SW-1:0];
  assign unused_bits = ^{mem_q[0], mem_q[1]};
  always_comb begin
    count_d = count_q + 2'(push) - 2'(pop);
    wr_d = wr_q ^ push;
    rd_d = rd_q ^ pop;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = '{data: N_MAX'(i_data[int'(g)*N +: N]), src: SW_MAX'(g)};
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule
